// File: rtl/controle_multiciclo_pkg.sv
// Shared types and encodings for the multicycle MIPS32 main control.
// State enum, opcode/funct constants, ALU operation codes and mux selects.
package controle_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    EXCEPT  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ULA_ADD = 3'b010;
  localparam logic [2:0] ULA_SUB = 3'b110;
  localparam logic [2:0] ULA_AND = 3'b000;
  localparam logic [2:0] ULA_OR  = 3'b001;
  localparam logic [2:0] ULA_SLT = 3'b111;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_EXC    = 2'b11;

  // True for the R-type funct codes the ALU implements.
  function automatic logic funct_valid(input logic [5:0] f);
    return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
           (f == FUNCT_OR)  || (f == FUNCT_SLT);
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Datapath <-> control bundle: IR fields, ALU flags, memory handshake and
// every control strobe/select. master = control unit, slave = datapath.
interface controle_multiciclo_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       ula_src_a;
  logic [1:0] ula_src_b;
  logic [2:0] ula_control;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       epc_write;

  modport master (
    input  op, funct, zero, overflow, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           ula_src_a, ula_src_b, ula_control, pc_src, pc_en, epc_write
  );

  modport slave (
    output op, funct, zero, overflow, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           ula_src_a, ula_src_b, ula_control, pc_src, pc_en, epc_write
  );
endinterface

// File: rtl/controle_multiciclo_decodificador_ula.sv
// R-type funct -> 3-bit ALU operation. Unknown functs fall back to add.
module decodificador_ula
  import controle_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] ula_control
);

  // Table lookup of the funct field.
  always_comb begin
    ula_control = ULA_ADD;
    case (funct)
      FUNCT_ADD: ula_control = ULA_ADD;
      FUNCT_SUB: ula_control = ULA_SUB;
      FUNCT_AND: ula_control = ULA_AND;
      FUNCT_OR:  ula_control = ULA_OR;
      FUNCT_SLT: ula_control = ULA_SLT;
      default:   ula_control = ULA_ADD;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore main control FSM for the multicycle MIPS32 datapath.
// Optional overflow/illegal-instruction trap: define CONTROLE_EXCEPTION_EN.
module controle_multiciclo
  import controle_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  controle_multiciclo_if.master     bus
);

  state_t     state, state_next;
  logic [2:0] dec_ctrl;
  logic       pc_write, branch;
  logic       mem_write_s, ir_write_s, reg_write_s, epc_write_s;

  decodificador_ula u_decodificador_ula (
    .funct       (bus.funct),
    .ula_control (dec_ctrl)
  );

  // State register; reset returns to instruction fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_next      = FETCH;
    bus.iord        = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.mem_to_reg  = 1'b0;
    reg_write_s     = 1'b0;
    bus.ula_src_a   = 1'b0;
    bus.ula_src_b   = SRC_B_REG;
    bus.ula_control = ULA_ADD;
    bus.pc_src      = PC_SRC_ALU;
    pc_write        = 1'b0;
    branch          = 1'b0;
    epc_write_s     = 1'b0;
    case (state)
      FETCH: begin
        bus.ula_src_b = SRC_B_FOUR;
        ir_write_s    = bus.mem_ready;
        pc_write      = bus.mem_ready;
        state_next    = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ula_src_b = SRC_B_IMM_SH;
        case (bus.op)
`ifdef CONTROLE_EXCEPTION_EN
          OP_RTYPE: state_next = funct_valid(bus.funct) ? EXECUTE : EXCEPT;
`else
          OP_RTYPE: state_next = EXECUTE;
`endif
          OP_LW, OP_SW: state_next = MEMADR;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDIEX;
          OP_J:         state_next = JUMP;
`ifdef CONTROLE_EXCEPTION_EN
          default:      state_next = EXCEPT;
`else
          default:      state_next = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        bus.ula_src_a = 1'b1;
        bus.ula_src_b = SRC_B_IMM;
        state_next    = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.iord   = 1'b1;
        state_next = bus.mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        reg_write_s    = 1'b1;
      end
      MEMWR: begin
        bus.iord    = 1'b1;
        mem_write_s = 1'b1;
        state_next  = bus.mem_ready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        bus.ula_src_a   = 1'b1;
        bus.ula_control = dec_ctrl;
        state_next      = ALUWB;
`ifdef CONTROLE_EXCEPTION_EN
        if (bus.overflow && (bus.funct == FUNCT_ADD || bus.funct == FUNCT_SUB))
          state_next = EXCEPT;
`endif
      end
      ALUWB: begin
        bus.reg_dst = 1'b1;
        reg_write_s = 1'b1;
      end
      BRANCH: begin
        bus.ula_src_a   = 1'b1;
        bus.ula_control = ULA_SUB;
        bus.pc_src      = PC_SRC_ALUOUT;
        branch          = 1'b1;
      end
      ADDIEX: begin
        bus.ula_src_a = 1'b1;
        bus.ula_src_b = SRC_B_IMM;
        state_next    = ADDIWB;
`ifdef CONTROLE_EXCEPTION_EN
        if (bus.overflow) state_next = EXCEPT;
`endif
      end
      ADDIWB: reg_write_s = 1'b1;
      JUMP: begin
        bus.pc_src = PC_SRC_JUMP;
        pc_write   = 1'b1;
      end
`ifdef CONTROLE_EXCEPTION_EN
      EXCEPT: begin
        epc_write_s = 1'b1;
        bus.pc_src  = PC_SRC_EXC;
        pc_write    = 1'b1;
      end
`endif
      default: state_next = FETCH;
    endcase
  end

  // Write strobes are gated by reset_n so an asynchronous reset suppresses
  // any write in the very cycle it arrives, not one edge later.
  assign bus.mem_write = mem_write_s & reset_n;
  assign bus.ir_write  = ir_write_s  & reset_n;
  assign bus.reg_write = reg_write_s & reset_n;
  assign bus.epc_write = epc_write_s & reset_n;
  assign bus.pc_en     = (pc_write | (branch & bus.zero)) & reset_n;

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Moore-style main control FSM for the multicycle MIPS32 datapath.
- Sits directly upstream of the 32-bit ALU: decodes op/funct into the 3-bit ALU control and mux selects, and sequences fetch/decode/execute/memory/writeback.
- Consumes the ALU's zero and overflow flags for branch resolution and the optional overflow exception.
- Contains the ALU function decoder as a sub-module.

Parameters:
- none

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- op  in  6  instruction opcode, from the IR
- funct  in  6  R-type funct field, from the IR
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed overflow flag
- mem_ready  in  1  memory access complete this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load enable
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- ula_src_a  out  1  ALU A input: 0 = PC, 1 = regA
- ula_src_b  out  2  ALU B input: 00 = regB, 01 = 4, 10 = signimm, 11 = signimm<<2
- ula_control  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = exception vector
- pc_en  out  1  PC load enable
- epc_write  out  1  EPC load enable

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. reset_n low forces the state to FETCH. While reset_n is low, mem_write, ir_write, reg_write, pc_en and epc_write are forced to 0. All other outputs show their FETCH values.
- State encoding: 4-bit state register. States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, EXCEPT=12. Codes 13-15 return to FETCH.
- Output decoding: outputs are combinational from the state, plus op/funct/zero/mem_ready where noted. Outputs not listed for a state are 0 (ula_control defaults to 010).
- pc_en = pc_write | (branch & zero). pc_write and branch are internal signals.
- FETCH: src_a=0, src_b=01, add, pc_src=00. ir_write = pc_write = mem_ready. Stay in FETCH while mem_ready is 0; go to DECODE when it is 1.
- DECODE: src_a=0, src_b=11, add (precomputes the branch target into ALUOut). Next state by op:
  - 000000 -> EXECUTE
  - 100011 / 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - other -> FETCH (executes as a nop)
- MEMADR: src_a=1, src_b=10, add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready, then go to FETCH. mem_write stays high for the whole wait.
- EXECUTE: src_a=1, src_b=00, ula_control = decoder(funct). Next: ALUWB.
- ALUWB: reg_dst=1, reg_write=1. Next: FETCH.
- BRANCH: src_a=1, src_b=00, sub, pc_src=01, branch=1. Next: FETCH.
- ADDIEX: src_a=1, src_b=10, add. Next: ADDIWB.
- ADDIWB: reg_dst=0, reg_write=1. Next: FETCH.
- JUMP: pc_src=10, pc_write=1. Next: FETCH.
- Funct decoder:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - other -> 010
- Latency in cycles, excluding mem_ready waits: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Reset asserted mid-instruction: takes effect immediately (asynchronous). No register or memory write may occur in that cycle.

Optional Feature:
- Macro: CONTROLE_EXCEPTION_EN
- Enabled, overflow trap:
  - EXECUTE with funct 100000/100010 and overflow=1 -> EXCEPT instead of ALUWB.
  - ADDIEX with overflow=1 -> EXCEPT instead of ADDIWB.
- Enabled, illegal instruction:
  - unknown op in DECODE -> EXCEPT.
  - R-type with an unknown funct in DECODE -> EXCEPT.
- EXCEPT state: epc_write=1, pc_src=11, pc_write=1. Next: FETCH. No reg_write occurs on the trapping instruction.
- Disabled: state 12 is unreachable (treated as 13-15, i.e. returns to FETCH); epc_write is tied 0; pc_src never equals 11; overflow is ignored.

Decomposition:
- Package controle_pkg holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ULA_ADD/ULA_SUB/ULA_AND/ULA_OR/ULA_SLT 3-bit codes
  - ula_src_b and pc_src encodings
- One sub-module: decodificador_ula (purely combinational funct -> ula_control; add/sub forcing is done in the parent).

Test Plan:
- Reset sequence: reset_n low mid-MEMWR with mem_write high -> all write enables drop to 0 in the same cycle; after release, FETCH with src_b=01, ula_control=010.
- lw (op=100011), mem_ready high in FETCH and MEMRD -> states 0,1,2,3,4,0. reg_write=1 only in MEMWB, with mem_to_reg=1 and reg_dst=0.
- sw with mem_ready low for 3 cycles in MEMWR -> mem_write held high 4 cycles; iord=1 throughout; then FETCH.
- beq in BRANCH: zero=1 -> pc_en=1, pc_src=01, ula_control=110. Repeat with zero=0 -> pc_en=0.
- R-type funct sweep 100000/100010/100100/100101/101010 -> EXECUTE ula_control 010/110/000/001/111; ALUWB reg_dst=1.
- CONTROLE_EXCEPTION_EN: add with overflow=1 in EXECUTE -> next EXCEPT with epc_write=1, pc_src=11, pc_en=1; no reg_write. Without the macro -> ALUWB with reg_write=1.
